vram_fill_engine: RTL and testbench
===================================

# vram_fill_engine

Bulk-write controller that shares the background VRAM write port between the CPU and a hardware fill engine. It sits between the CPU bus decode and the background renderer's `data_in`/`address`/`write_enable` inputs. Its main use is clearing or initialising nametable and pattern regions (for example, filling tiles 0x400–0x7BF) without the CPU spending one bus cycle per byte. The CPU always wins the port; the engine uses only cycles the CPU leaves idle, and can be restricted to vertical blanking.

## Interface
Parameters:
- `ADDR_W`, default `` `VRAM_ADDR_WIDTH `` (12): VRAM byte address width.
- `LEN_W`, default 11: width of the fill length; maximum fill is 2047 bytes.

Ports:
- `cpu_clk` in 1: the single block clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_clk_enable` in 1: state advances only on posedges where this is 1.
- `cpu_data` in 8: CPU write data.
- `cpu_address` in ADDR_W: CPU write address.
- `cpu_write_enable` in 1: CPU write request.
- `fill_start` in 1: start request; sampled on enabled edges.
- `fill_base` in ADDR_W: first address of the fill.
- `fill_len` in LEN_W: number of bytes to write; 0 means no writes.
- `fill_value` in 8: first data byte.
- `fill_incr` in 1: 0 = constant data; 1 = data increments by 1 per byte, mod 256.
- `fill_vblank_only` in 1: 1 = engine writes only while `vblank` is 1.
- `fill_abort` in 1: stop the current fill.
- `vblank` in 1: from video timing; treated as synchronous to `cpu_clk`.
- `busy` out 1: engine not IDLE.
- `done` out 1: one-enabled-cycle pulse when a fill ends.
- `aborted` out 1: valid while `done` is 1; 1 = the fill ended by abort.
- `vram_data` out 8, `vram_address` out ADDR_W, `vram_write_enable` out 1: to the background renderer.

## Operation
- States are IDLE, RUN, DONE. Reset puts the block in IDLE and clears all registers to 0.
- All outputs are 0 in reset, except that `vram_*` follow the CPU pass-through.
- IDLE:
  - On `fill_start`, latch base, len, value, incr and vblank_only into `addr_q`, `rem_q`, `data_q`, `incr_q` and `vbo_q`.
  - If `rem_q` would be 0, go to DONE with `aborted=0`. Otherwise go to RUN.
- Grant rule: `eng_grant = (state==RUN) & ~cpu_write_enable & (~vbo_q | vblank)`.
- Port mux (combinational):
  - If `cpu_write_enable`, drive the CPU address, data and write enable.
  - Else if `eng_grant`, drive `addr_q`, `data_q` and write enable 1.
  - Else drive write enable 0; address and data hold the CPU values.
- RUN, on an enabled edge where `eng_grant` is 1:
  - `addr_q` increments by 1 and wraps modulo 2^ADDR_W (0xFFF → 0x000).
  - `data_q` increments by 1 if `incr_q` is set.
  - `rem_q` decrements; when it reaches 0, go to DONE with `aborted=0`.
- RUN, on an enabled edge with `eng_grant` = 0: the engine stalls and all registers hold.
- `fill_abort` in RUN: go to DONE with `aborted=1`. Abort has priority over a same-edge grant advance, but the grant's write is still presented during that cycle. `fill_abort` in IDLE or DONE is ignored.
- DONE: `done` is 1; the next enabled edge returns to IDLE.
- `fill_start` while the state is RUN or DONE is ignored; it is not queued.

## Timing
- With `fill_start` sampled at enabled edge k, `busy` is 1 from after edge k.
- The first engine write is presented during the cycle after edge k. The VRAM commits it on the following negedge.
- With no stalls and length N, writes are presented after edges k … k+N−1.
- The state is DONE after edge k+N, so `done` is high between edges k+N and k+N+1. The state is IDLE after edge k+N+1.
- Each stalled enabled cycle adds exactly one cycle to this timing.
- Cycles with `cpu_clk_enable` = 0 change no state. The mux still follows its inputs during them.
- Asynchronous reset mid-fill: outputs drop immediately, and the partial fill is not resumed.

## Structure
- Shared package `gpu_pkg` holds:
  - the `fill_state_t` enum {IDLE, RUN, DONE};
  - the VRAM region constants `PMB_BASE` 0x200, `NTBL_BASE` 0x400, `NTBL_COLORS_ADDR` 0x7C0.
- One sub-module, `vram_port_mux`: the combinational CPU/engine mux and grant logic.
- The FSM and counters stay in `vram_fill_engine`.

## Test plan
- Nametable clear: base 0x400, len 960, value 0x00, no CPU traffic → 960 writes to 0x400–0x7BF. `done` pulses 961 enabled edges after start, with `aborted` = 0.
- Incrementing and wrap: base 0xFFE, len 4, value 0xFE, incr 1 → writes (0xFFE,0xFE), (0xFFF,0xFF), (0x000,0x00), (0x001,0x01).
- CPU priority: during a 16-byte fill, the CPU writes 0x5A to 0x7C0 on 3 enabled cycles → the CPU writes pass unchanged. The engine still writes all 16 bytes in order, and `done` is delayed by exactly 3 cycles.
- Vblank gating: vblank_only 1, `vblank` low for 10 cycles → no engine writes and `busy` stays 1. Writes begin in the first cycle with `vblank` high.
- Abort at remaining count 5, and start while busy → `done` with `aborted` = 1, no further writes, and the second start is ignored. A len-0 start gives `done` one edge later with no writes.
- `rst` asserted mid-fill with `cpu_clk` stopped → `busy`, `done` and the engine write enable drop immediately. After release the block is in IDLE.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM address width, region map and the fill-engine state encoding.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam logic [11:0] PMB_BASE         = 12'h200;
    localparam logic [11:0] NTBL_BASE        = 12'h400;
    localparam logic [11:0] NTBL_COLORS_ADDR = 12'h7C0;

endpackage

// File: rtl/vram_port_mux.sv
// Shares the background VRAM write port: the CPU always wins, the fill engine
// only gets cycles the CPU leaves idle (optionally only during vblank).
module vram_port_mux
    import gpu_pkg::*;
#(
    parameter int ADDR_W = `VRAM_ADDR_WIDTH
) (
    input  fill_state_t       state,
    input  logic              vbo_q,
    input  logic              vblank,
    input  logic              cpu_write_enable,
    input  logic [7:0]        cpu_data,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [ADDR_W-1:0] addr_q,
    input  logic [7:0]        data_q,
    output logic              eng_grant,
    output logic [7:0]        vram_data,
    output logic [ADDR_W-1:0] vram_address,
    output logic              vram_write_enable
);

    // Address and data default to the CPU values even when nobody writes.
    always_comb begin
        eng_grant         = (state == RUN) & ~cpu_write_enable & (~vbo_q | vblank);
        vram_address      = cpu_address;
        vram_data         = cpu_data;
        vram_write_enable = cpu_write_enable;
        if (!cpu_write_enable && eng_grant) begin
            vram_address      = addr_q;
            vram_data         = data_q;
            vram_write_enable = 1'b1;
        end
    end

endmodule

// File: rtl/vram_fill_engine.sv
// Hardware bulk-fill controller for background VRAM: FSM and address/data/length
// counters, with the port arbitration delegated to vram_port_mux.
module vram_fill_engine
    import gpu_pkg::*;
#(
    parameter int ADDR_W = `VRAM_ADDR_WIDTH,
    parameter int LEN_W  = 11
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              cpu_clk_enable,
    input  logic [7:0]        cpu_data,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_write_enable,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [LEN_W-1:0]  fill_len,
    input  logic [7:0]        fill_value,
    input  logic              fill_incr,
    input  logic              fill_vblank_only,
    input  logic              fill_abort,
    input  logic              vblank,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [7:0]        vram_data,
    output logic [ADDR_W-1:0] vram_address,
    output logic              vram_write_enable
);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        data_q, data_d;
    logic              incr_q, incr_d;
    logic              vbo_q, vbo_d;
    logic              abort_q, abort_d;
    logic              eng_grant;

    vram_port_mux #(.ADDR_W(ADDR_W)) u_port_mux (
        .state             (state_q),
        .vbo_q             (vbo_q),
        .vblank            (vblank),
        .cpu_write_enable  (cpu_write_enable),
        .cpu_data          (cpu_data),
        .cpu_address       (cpu_address),
        .addr_q            (addr_q),
        .data_q            (data_q),
        .eng_grant         (eng_grant),
        .vram_data         (vram_data),
        .vram_address      (vram_address),
        .vram_write_enable (vram_write_enable)
    );

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            incr_q  <= 1'b0;
            vbo_q   <= 1'b0;
            abort_q <= 1'b0;
        end else if (cpu_clk_enable) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            incr_q  <= incr_d;
            vbo_q   <= vbo_d;
            abort_q <= abort_d;
        end
    end

    // Abort wins over a same-edge advance; the granted write is still on the port that cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        incr_d  = incr_q;
        vbo_d   = vbo_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    addr_d  = fill_base;
                    rem_d   = fill_len;
                    data_d  = fill_value;
                    incr_d  = fill_incr;
                    vbo_d   = fill_vblank_only;
                    abort_d = 1'b0;
                    state_d = (fill_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fill_abort) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (eng_grant) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (incr_q) begin
                        data_d = data_q + 8'd1;
                    end
                    if (rem_q == LEN_W'(1)) begin
                        abort_d = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign aborted = (state_q == DONE) & abort_q;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Directed self-checking bench for vram_fill_engine: fills, wrap, CPU priority,
// vblank gating, abort, zero length and asynchronous reset with the clock stopped.
module tb_vram_fill_engine;

    logic        cpu_clk = 1'b0;
    bit          clkRun  = 1'b1;
    logic        rst;
    logic        cpu_clk_enable;
    logic [7:0]  cpu_data;
    logic [11:0] cpu_address;
    logic        cpu_write_enable;
    logic        fill_start;
    logic [11:0] fill_base;
    logic [10:0] fill_len;
    logic [7:0]  fill_value;
    logic        fill_incr;
    logic        fill_vblank_only;
    logic        fill_abort;
    logic        vblank;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  vram_data;
    logic [11:0] vram_address;
    logic        vram_write_enable;

    int compareCount = 0;
    int failCount    = 0;
    int cycNow       = 0;

    typedef struct packed {
        int          cyc;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wq[$];

    int   edges, doneCyc, cpuErr, busyErr;
    logic ab;

    vram_fill_engine dut (
        .cpu_clk           (cpu_clk),
        .rst               (rst),
        .cpu_clk_enable    (cpu_clk_enable),
        .cpu_data          (cpu_data),
        .cpu_address       (cpu_address),
        .cpu_write_enable  (cpu_write_enable),
        .fill_start        (fill_start),
        .fill_base         (fill_base),
        .fill_len          (fill_len),
        .fill_value        (fill_value),
        .fill_incr         (fill_incr),
        .fill_vblank_only  (fill_vblank_only),
        .fill_abort        (fill_abort),
        .vblank            (vblank),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .vram_data         (vram_data),
        .vram_address      (vram_address),
        .vram_write_enable (vram_write_enable)
    );

    always #5 if (clkRun) cpu_clk = ~cpu_clk;

    // Engine writes the VRAM commits on the negedge of an enabled cycle.
    always @(negedge cpu_clk) begin
        if (rst && cpu_clk_enable && vram_write_enable && !cpu_write_enable) begin
            wr_t w;
            w.cyc = cycNow;
            w.a   = vram_address;
            w.d   = vram_data;
            wq.push_back(w);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic startFill(input logic [11:0] b, input logic [10:0] l, input logic [7:0] v,
                             input logic inc, input logic vbo);
        wq.delete();
        cycNow           = 0;
        fill_base        = b;
        fill_len         = l;
        fill_value       = v;
        fill_incr        = inc;
        fill_vblank_only = vbo;
        fill_start       = 1'b1;
        @(posedge cpu_clk);
        #1;
        fill_start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
    endtask

    // Cycle c=1 is the cycle after the start edge; edges counts enabled edges including the start edge.
    task automatic applyStimulus(input int limit, input logic [63:0] cpuMask, input logic [63:0] disMask,
                                 input int vblankFrom, input int abortAt, input int startAt,
                                 output int nEdges, output int dCyc, output logic abOut,
                                 output int cErr, output int bErr);
        nEdges = 1;
        dCyc   = 0;
        abOut  = 1'b0;
        cErr   = 0;
        bErr   = 0;
        for (int c = 1; c <= limit; c++) begin
            cycNow           = c;
            cpu_write_enable = (c < 64) ? cpuMask[c[5:0]] : 1'b0;
            cpu_clk_enable   = (c < 64) ? ~disMask[c[5:0]] : 1'b1;
            vblank           = (c >= vblankFrom);
            fill_abort       = (c == abortAt);
            fill_start       = (c == startAt);
            @(negedge cpu_clk);
            if (cpu_write_enable &&
                (vram_address !== 12'h7C0 || vram_data !== 8'h5A || vram_write_enable !== 1'b1))
                cErr++;
            if (done === 1'b1) begin
                dCyc  = c;
                abOut = aborted;
                break;
            end
            if (busy !== 1'b1) bErr++;
            @(posedge cpu_clk);
            if (cpu_clk_enable) nEdges++;
            #1;
        end
        cpu_write_enable = 1'b0;
        cpu_clk_enable   = 1'b1;
        fill_abort       = 1'b0;
        fill_start       = 1'b0;
        @(posedge cpu_clk);
        #1;
        cycNow = 0;
    endtask

    task automatic checkSeq(input string tag, input logic [11:0] base, input logic [7:0] value,
                            input bit inc, input int n);
        int          errs;
        logic [11:0] ea;
        logic [7:0]  ed;
        errs = 0;
        checkOutput({tag, "_count"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            ea = base + 12'(i);
            ed = inc ? value + 8'(i) : value;
            if (wq[i].a !== ea || wq[i].d !== ed) errs++;
        end
        checkOutput({tag, "_seq_errs"}, errs, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b0;
        cpu_clk_enable   = 1'b1;
        cpu_data         = 8'h5A;
        cpu_address      = 12'h7C0;
        cpu_write_enable = 1'b1;
        fill_start       = 1'b0;
        fill_base        = '0;
        fill_len         = '0;
        fill_value       = '0;
        fill_incr        = 1'b0;
        fill_vblank_only = 1'b0;
        fill_abort       = 1'b0;
        vblank           = 1'b0;
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_cpu_addr", vram_address, 12'h7C0);
        checkOutput("rst_cpu_data", vram_data, 8'h5A);
        checkOutput("rst_cpu_we", vram_write_enable, 1);
        cpu_write_enable = 1'b0;
        #1;
        checkOutput("rst_idle_we", vram_write_enable, 0);
        #10;
        rst = 1'b1;
        @(posedge cpu_clk);
        #1;

        // Nametable clear: 960 zero bytes to 0x400..0x7BF.
        startFill(12'h400, 11'd960, 8'h00, 1'b0, 1'b0);
        applyStimulus(1100, 64'd0, 64'd0, 0, 0, 0, edges, doneCyc, ab, cpuErr, busyErr);
        checkOutput("clear_done_edges", edges, 961);
        checkOutput("clear_aborted", ab, 0);
        checkOutput("clear_busy_held", busyErr, 0);
        checkSeq("clear", 12'h400, 8'h00, 1'b0, 960);
        checkOutput("clear_last_addr", (wq.size() > 0) ? 32'(wq[wq.size()-1].a) : 32'hFFFF_FFFF, 12'h7BF);
        checkOutput("clear_done_low", done, 0);
        checkOutput("clear_busy_low", busy, 0);

        // Incrementing data with address wrap; cycle 2 has the clock enable low.
        startFill(12'hFFE, 11'd4, 8'hFE, 1'b1, 1'b0);
        applyStimulus(40, 64'd0, 64'h4, 0, 0, 0, edges, doneCyc, ab, cpuErr, busyErr);
        checkOutput("wrap_done_edges", edges, 5);
        checkOutput("wrap_done_cycle", doneCyc, 6);
        checkOutput("wrap_count", wq.size(), 4);
        checkOutput("wrap_w0", (wq.size() > 0) ? 32'({wq[0].a, wq[0].d}) : 32'hFFFF_FFFF, {12'hFFE, 8'hFE});
        checkOutput("wrap_w1", (wq.size() > 1) ? 32'({wq[1].a, wq[1].d}) : 32'hFFFF_FFFF, {12'hFFF, 8'hFF});
        checkOutput("wrap_w2", (wq.size() > 2) ? 32'({wq[2].a, wq[2].d}) : 32'hFFFF_FFFF, {12'h000, 8'h00});
        checkOutput("wrap_w3", (wq.size() > 3) ? 32'({wq[3].a, wq[3].d}) : 32'hFFFF_FFFF, {12'h001, 8'h01});
        checkOutput("wrap_w1_cycle", (wq.size() > 1) ? 32'(wq[1].cyc) : 32'hFFFF_FFFF, 3);

        // CPU priority: CPU writes 0x5A to 0x7C0 on cycles 2, 5 and 9.
        startFill(12'h200, 11'd16, 8'h11, 1'b1, 1'b0);
        applyStimulus(60, 64'h224, 64'd0, 0, 0, 0, edges, doneCyc, ab, cpuErr, busyErr);
        checkOutput("cpu_done_edges", edges, 20);
        checkOutput("cpu_passthru_errs", cpuErr, 0);
        checkOutput("cpu_aborted", ab, 0);
        checkSeq("cpu", 12'h200, 8'h11, 1'b1, 16);

        // Vblank gating: vblank low for cycles 1..10.
        startFill(12'h100, 11'd3, 8'h77, 1'b0, 1'b1);
        applyStimulus(60, 64'd0, 64'd0, 11, 0, 0, edges, doneCyc, ab, cpuErr, busyErr);
        checkOutput("vbl_done_edges", edges, 14);
        checkOutput("vbl_busy_held", busyErr, 0);
        checkOutput("vbl_first_cycle", (wq.size() > 0) ? 32'(wq[0].cyc) : 32'hFFFF_FFFF, 11);
        checkSeq("vbl", 12'h100, 8'h77, 1'b0, 3);

        // Abort with 5 bytes left (cycle 6) and an ignored start on cycle 3.
        startFill(12'h300, 11'd10, 8'h20, 1'b0, 1'b0);
        fill_base = 12'h600;
        fill_len  = 11'd2;
        applyStimulus(60, 64'd0, 64'd0, 0, 6, 3, edges, doneCyc, ab, cpuErr, busyErr);
        checkOutput("abort_done_edges", edges, 7);
        checkOutput("abort_aborted", ab, 1);
        repeat (4) @(posedge cpu_clk);
        #1;
        checkSeq("abort", 12'h300, 8'h20, 1'b0, 6);
        checkOutput("abort_idle_busy", busy, 0);

        // Zero-length fill: done one edge after start, no writes.
        startFill(12'h050, 11'd0, 8'h33, 1'b0, 1'b0);
        applyStimulus(20, 64'd0, 64'd0, 0, 0, 0, edges, doneCyc, ab, cpuErr, busyErr);
        checkOutput("len0_done_edges", edges, 1);
        checkOutput("len0_aborted", ab, 0);
        checkOutput("len0_writes", wq.size(), 0);

        // Asynchronous reset mid-fill with the clock stopped high.
        startFill(12'h000, 11'd100, 8'hAA, 1'b0, 1'b0);
        repeat (3) @(posedge cpu_clk);
        #1;
        checkOutput("arst_pre_we", vram_write_enable, 1);
        clkRun = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_we", vram_write_enable, 0);
        #10;
        rst = 1'b1;
        #2;
        wq.delete();
        clkRun = 1'b1;
        repeat (5) @(posedge cpu_clk);
        #1;
        checkOutput("arst_idle_busy", busy, 0);
        checkOutput("arst_no_resume", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
